rr_burst_sched: RTL and testbench

Round-robin burst scheduler that shares one beat-oriented resource (a bus port or memory write channel) among up to 16 requesters. It holds a grant across a multi-beat burst until the owner signals its last beat, drops its request, or hits a configurable beat limit. Grant rotates fairly after each release. It sits between the requester interfaces and the shared resource, driving the resource's owner select.

---
 rtl/rr_burst_sched.sv | 128 ++++++++++++
 tb/tb_rr_burst_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | rr_burst_sched : round-robin burst scheduler, grant held until last/abort
// | Optional hold limit: define RR_SCHED_HOLD_LIMIT_EN.   Revision: 1.0
// +-----------------------------------------------------------------------------
module rr_burst_sched #(
  parameter int N       = 16,
  parameter int IDW     = 4,
  parameter int MAXHOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  input  logic           beat,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld,
  output logic           ovr
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  generate
    if (N < 2 || N > 16 || IDW != $clog2(N) || MAXHOLD < 1 || MAXHOLD > 255) begin : g_bad_param
      $error("rr_burst_sched: parameter out of range");
    end
  endgenerate

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic           w_sel_found;
  logic [IDW-1:0] w_sel_id;
  logic [IDW:0]   w_idx;
  logic [IDW-1:0] w_next_ptr;
  logic           w_own_req;
  logic           w_own_done;
  logic           w_release;

  // Rotating search starting at r_ptr; the first set request wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = '0;
    w_idx       = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_idx >= (IDW+1)'(N)) begin
        w_idx = w_idx - (IDW+1)'(N);
      end
      if (!w_sel_found && req[w_idx[IDW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_id    = w_idx[IDW-1:0];
      end
    end
  end

  // gnt_id doubles as the owner register while BUSY.
  assign w_own_req  = req[gnt_id];
  assign w_own_done = beat & last[gnt_id];
  assign w_next_ptr = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;

`ifdef RR_SCHED_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(MAXHOLD + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_force;

  // Forced release only when neither abort nor normal release applies.
  assign w_force   = w_own_req & ~w_own_done & beat & (r_cnt == CNT_W'(MAXHOLD - 1));
  assign w_release = ~w_own_req | w_own_done | w_force;
`else
  assign w_release = ~w_own_req | w_own_done;
  assign ovr       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
`ifdef RR_SCHED_HOLD_LIMIT_EN
      r_cnt   <= '0;
      ovr     <= 1'b0;
`endif
    end else begin
`ifdef RR_SCHED_HOLD_LIMIT_EN
      ovr <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_sel_found) begin
            r_state <= BUSY;
            gnt     <= ONE_HOT0 << w_sel_id;
            gnt_id  <= w_sel_id;
            gnt_vld <= 1'b1;
`ifdef RR_SCHED_HOLD_LIMIT_EN
            r_cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          if (w_release) begin
            r_state <= IDLE;
            r_ptr   <= w_next_ptr;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
`ifdef RR_SCHED_HOLD_LIMIT_EN
            ovr     <= w_force;
          end else if (beat) begin
            r_cnt   <= r_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_burst_sched.sv
`default_nettype none
// Scoreboard bench for rr_burst_sched: random and directed traffic vs. a queue-based model.
module tb_rr_burst_sched;

  localparam int N       = 16;
  localparam int IDW     = 4;
  localparam int MAXHOLD = 8;
`ifdef RR_SCHED_HOLD_LIMIT_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   last = '0;
  logic           beat = 1'b0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic           ovr;

  rr_burst_sched #(.N(N), .IDW(IDW), .MAXHOLD(MAXHOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .beat(beat),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .ovr(ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    int           id;
    logic         vld;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: owner index or -1, rotating pointer, beats taken by owner.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, queue the expected outputs.
  task automatic drive(input logic r, input logic [N-1:0] q, input logic [N-1:0] l, input logic b);
    exp_t e;
    int   o;
    rst  = r;
    req  = q;
    last = l;
    beat = b;
    e.ov = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_owner < 0 && q[idx[IDW-1:0]]) begin
          m_owner = idx;
          m_cnt   = 0;
        end
      end
    end else begin
      bit rel;
      rel = 1'b0;
      o   = m_owner;
      if (!q[o[IDW-1:0]]) rel = 1'b1;
      else if (b && l[o[IDW-1:0]]) rel = 1'b1;
      else if (HOLD && b && m_cnt == MAXHOLD - 1) begin
        rel  = 1'b1;
        e.ov = 1'b1;
      end else if (b) m_cnt++;
      if (rel) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    e.g   = '0;
    e.vld = (m_owner >= 0);
    e.id  = e.vld ? m_owner : 0;
    if (e.vld) begin
      o = m_owner;
      e.g[o[IDW-1:0]] = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per edge, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("gnt",     32'(gnt),     32'(e.g));
        check("gnt_id",  32'(gnt_id),  32'(e.id));
        check("gnt_vld", 32'(gnt_vld), 32'(e.vld));
        check("ovr",     32'(ovr),     32'(e.ov));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] rl;

    // Reset state, then single requester 0.
    drive(1, '0, '0, 0);
    drive(1, '0, '0, 0);
    drive(0, '0, '0, 0);
    drive(0, 16'h0001, '0, 0);
    drive(0, 16'h0001, '0, 0);
    drive(0, 16'h0001, 16'h0001, 1);
    drive(0, '0, '0, 0);

    // All requesting, single-beat bursts: 0..15 then 0 again.
    drive(1, '0, '0, 0);
    for (int i = 0; i < 34; i++) drive(0, 16'hFFFF, 16'hFFFF, m_owner >= 0);

    // Wrap: id 15 releases, then 15 and 0 requesting -> 0 wins.
    drive(1, '0, '0, 0);
    for (int i = 0; i < 3; i++) drive(0, 16'h8000, 16'hFFFF, m_owner >= 0);
    for (int i = 0; i < 3; i++) drive(0, 16'h8001, '0, 0);

    // Hold limit on id 3 with id 5 waiting.
    drive(1, '0, '0, 0);
    for (int i = 0; i < 16; i++) drive(0, 16'h0028, '0, 1);

    // Abort after 2 beats on id 6, then ptr=7 shows via 0x81 -> 7.
    drive(1, '0, '0, 0);
    drive(0, 16'h0040, '0, 0);
    drive(0, 16'h0040, '0, 1);
    drive(0, 16'h0040, '0, 1);
    drive(0, '0, '0, 0);
    drive(0, 16'h0081, '0, 0);
    drive(0, 16'h0081, '0, 0);

    // Reset mid-burst on id 9; next grant from ptr=0 is id 0.
    drive(1, '0, '0, 0);
    drive(0, 16'h0200, '0, 0);
    drive(0, 16'h0200, '0, 1);
    drive(1, 16'h0201, '0, 1);
    drive(0, 16'h0201, '0, 0);
    drive(0, 16'h0201, '0, 0);

    // Randomized traffic.
    rq = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom) & N'($urandom);
      rl = N'($urandom) & N'($urandom);
      drive($urandom_range(0, 199) == 0, rq, rl, 1'($urandom));
    end
    drive(0, '0, '0, 0);

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
